// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: one bit per cycle in CALC,
// with fast paths for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_mq;
    logic [XLEN-1:0]   r_b;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;

    // Accept-cycle decode
    logic              w_op1_signed;
    logic              w_op2_signed;
    logic              w_neg1;
    logic              w_neg2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_div0;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic              w_accept;
    logic              w_last;

    // Iteration datapath
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [XLEN-1:0]   w_acc_nxt;
    logic [XLEN-1:0]   w_mq_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_sel;
    logic [XLEN-1:0]   w_final;

    assign w_op1_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign w_op2_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign w_neg1       = w_op1_signed & op1[XLEN-1];
    assign w_neg2       = w_op2_signed & op2[XLEN-1];
    assign w_mag1       = w_neg1 ? -op1 : op1;
    assign w_mag2       = w_neg2 ? -op2 : op2;

    assign w_div0     = op[2] && (op2 == '0);
    assign w_ovf      = op[2] && !op[0] && (op1 == MIN_NEG) && (op2 == '1);
    assign w_fast     = w_div0 || w_ovf;
    assign w_fast_res = w_div0 ? (op[1] ? op1 : '1) : (op[1] ? '0 : op1);
    assign w_accept   = (r_state == IDLE) && start && !flush;
    assign w_last     = (r_cnt == LAST);

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign result = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = w_fast ? DONE : CALC;
            CALC:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    // Multiply: {acc, mq} shifts right, adding the multiplicand when mq[0] is set.
    // Divide: {acc, mq} shifts left, restoring when the trial subtraction borrows.
    always_comb begin
        w_sum     = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : '0);
        w_shift   = {r_acc, r_mq[XLEN-1]};
        w_diff    = w_shift - {1'b0, r_b};
        w_acc_nxt = w_sum[XLEN:1];
        w_mq_nxt  = {w_sum[0], r_mq[XLEN-1:1]};
        if (r_op[2]) begin
            w_acc_nxt = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            w_mq_nxt  = {r_mq[XLEN-2:0], ~w_diff[XLEN]};
        end
    end

    always_comb begin
        w_prod  = {w_acc_nxt, w_mq_nxt};
        w_sel   = r_op[1] ? w_acc_nxt : w_mq_nxt;
        w_final = r_neg ? -w_sel : w_sel;
        if (!r_op[2]) begin
            if (r_neg) w_prod = -w_prod;
            w_final = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_mq     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= op;
            r_cnt <= '0;
            r_acc <= '0;
            if (op[2]) begin
                r_mq  <= w_mag1;
                r_b   <= w_mag2;
                r_neg <= op[1] ? w_neg1 : (w_neg1 ^ w_neg2);
            end else begin
                r_mq  <= w_mag2;
                r_b   <= w_mag1;
                r_neg <= w_neg1 ^ w_neg2;
            end
            if (w_fast) r_result <= w_fast_res;
        end else if ((r_state == CALC) && !flush) begin
            r_acc <= w_acc_nxt;
            r_mq  <= w_mq_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_result <= w_final;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: XLEN=32 instance for the main function,
// fast paths, flush, ignored start and reset; XLEN=8 instance for MULHSU.
module tb_muldiv_unit;

    localparam int LIMIT = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush;
    logic [2:0]  op;
    logic [31:0] op1, op2;
    logic        busy, done;
    logic [31:0] result;

    logic        s8_start, s8_flush;
    logic [2:0]  s8_op;
    logic [7:0]  s8_op1, s8_op2;
    logic        s8_busy, s8_done;
    logic [7:0]  s8_result;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    logic seen;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start), .op(op), .op1(op1), .op2(op2),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    muldiv_unit #(.XLEN(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .op(s8_op), .op1(s8_op1), .op2(s8_op2),
        .flush(s8_flush), .busy(s8_busy), .done(s8_done), .result(s8_result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is in cycle first_cycle; returns the cycle in which done was seen.
    task automatic wait_done(input int first_cycle, output int cyc);
        cyc = first_cycle;
        while (!done && cyc < LIMIT) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int c;
        start = 1'b1; op = o; op1 = a; op2 = b;
        tick();
        start = 1'b0; op = ~o; op1 = ~a; op2 = b ^ 32'h5A5A_A5A5;
        wait_done(1, c);
        check({tag, "_latency"}, 64'(c), 64'(exp_lat));
        check({tag, "_result"}, 64'(result), 64'(exp));
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; op1 = '0; op2 = '0;
        s8_start = 1'b0; s8_flush = 1'b0; s8_op = '0; s8_op1 = '0; s8_op2 = '0;
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        rst = 1'b0;

        run_op("mul",    3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh",   3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_op("mulhu",  3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("divu",   3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu",   3'b111, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu_z", 3'b101, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_z",  3'b110, 32'h1234, 32'd0, 32'h0000_1234, 1);
        run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

        // Flush in cycle 10 of a DIV: idle in cycle 11, no done, result kept.
        start = 1'b1; op = 3'b100; op1 = 32'd1000; op2 = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            if (done) seen = 1'b1;
            tick();
        end
        check("flush_no_done", 64'(seen), 64'd0);
        check("flush_result_kept", 64'(result), 64'h8000_0000);

        run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // A second start in cycle 5 of a MUL must be ignored.
        start = 1'b1; op = 3'b000; op1 = 32'd12345; op2 = 32'd678;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; op = 3'b101; op1 = 32'd5; op2 = 32'd0;
        tick();
        start = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        wait_done(6, lat);
        check("restart_latency", 64'(lat), 64'd33);
        check("restart_result", 64'(result), 64'h007F_B6F6);
        tick();
        check("restart_no_second", 64'(busy), 64'd0);

        // flush and start together in IDLE: not accepted.
        start = 1'b1; flush = 1'b1; op = 3'b000; op1 = 32'd3; op2 = 32'd3;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", 64'(busy), 64'd0);

        // Reset mid-CALC aborts and clears the result.
        start = 1'b1; op = 3'b011; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_result", 64'(result), 64'd0);
        rst = 1'b0;
        run_op("post_rst", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        // XLEN=8 MULHSU: -128 * 255 = 0x8080, upper byte 0x80.
        s8_start = 1'b1; s8_op = 3'b010; s8_op1 = 8'h80; s8_op2 = 8'hFF;
        tick();
        s8_start = 1'b0; s8_op = 3'b000; s8_op1 = 8'h01; s8_op2 = 8'h01;
        lat = 1;
        while (!s8_done && lat < LIMIT) begin
            tick();
            lat++;
        end
        check("x8_mulhsu_latency", 64'(lat), 64'd9);
        check("x8_mulhsu_result", 64'(s8_result), 64'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, setting the operand and result width (legal values: 8, 16, 32, 64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request; accepted only while busy=0.
REQ-005 The block SHALL have port op, input, 3 bits: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU (RV32M funct3 encoding).
REQ-006 The block SHALL have ports op1 and op2, input, XLEN bits each: operands (op1 = rs1, op2 = rs2), sampled only on the accept cycle.
REQ-007 The block SHALL have port flush, input, 1 bit: abort the in-flight operation (pipeline kill).
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 The block SHALL have port result, output, XLEN bits: operation result, held stable until the next done pulse.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and DONE.
REQ-012 IDLE -> CALC SHALL occur on start=1 with a normal operation (accept cycle = cycle 0).
REQ-013 The block SHALL remain in CALC for exactly XLEN cycles, processing 1 bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-014 CALC -> DONE SHALL occur after the XLEN-th iteration; in DONE: done=1, result updated; DONE -> IDLE on the next cycle.
REQ-015 Normal latency SHALL be: done high in cycle XLEN+1 after accept (cycle 33 for XLEN=32); the next start is accepted in cycle XLEN+2 at the earliest.
REQ-016 Operands and op SHALL be latched on the accept cycle; later changes to op/op1/op2 SHALL have no effect on the operation in flight.
REQ-017 Signed operations SHALL be computed on magnitudes with the sign restored at the end. Quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1). MULHSU treats op1 as signed and op2 as unsigned.
REQ-018 MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN] of the 2*XLEN-bit product.
REQ-019 Divide by zero (op2=0) SHALL take the fast path IDLE -> DONE, with done in cycle 1. Results: DIV/DIVU = all ones; REM/REMU = op1.
REQ-020 Signed overflow (DIV/REM with op1 = most negative value and op2 = all ones) SHALL take the fast path, with done in cycle 1. Results: DIV = op1; REM = 0.
REQ-021 start while busy=1 SHALL be ignored, without queueing.
REQ-022 flush=1 SHALL force IDLE on the next edge from any state, with no done pulse (even if DONE would have been entered that edge), and SHALL leave result unchanged.
REQ-023 flush=1 together with start=1 in IDLE SHALL cause flush to win: not accepted, block stays idle.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL set: state = IDLE, busy = 0, done = 0, result = 0, internal accumulators and counter = 0.
REQ-025 rst SHALL take priority over start and flush; asserting it mid-CALC SHALL abort with no done pulse.
REQ-026 The first start SHALL be accepted in the cycle after rst deasserts.

Verification
REQ-027 The bench SHALL check: XLEN=32, MUL op1=7, op2=0xFFFFFFFD (-3) -> done exactly 33 cycles after accept, result 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
REQ-028 The bench SHALL check: DIV op1=-7 (0xFFFFFFF9), op2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-029 The bench SHALL check: DIVU op2=0, op1=0x1234 -> done in cycle 1, result 0xFFFFFFFF; REM op1=0x1234, op2=0 -> 0x1234.
REQ-030 The bench SHALL check: DIV op1=0x80000000, op2=0xFFFFFFFF -> done in cycle 1, result 0x80000000; REM same operands -> 0.
REQ-031 The bench SHALL check: start a DIV, pulse flush in cycle 10 -> busy=0 in cycle 11, no done, result retains its prior value; start re-pulsed in cycle 5 of a MUL -> ignored, first result correct.
REQ-032 The bench SHALL check: rst asserted mid-CALC -> next cycle busy=0, done=0, result=0; XLEN=8 instance, MULHSU op1=0x80, op2=0xFF -> done in cycle 9, result 0x80.
